// File: rtl/md_unit_if.sv
// ============================================================================
// md_unit_if : EX-stage handshake/result bundle for the multiply/divide unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface md_unit_if;
  logic        en;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_id;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output en, op, a, b, md_use_id,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  en, op, a, b, md_use_id,
    output busy, stall_req, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// md_unit : multi-cycle multiply/divide unit with architectural HI/LO
// Rev 1.0
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_run  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi_n;
  logic [31:0]      r_lo_n;
  logic             r_commit;

  logic             w_busy;
  logic             w_stall_req;
  logic             w_start;
  logic             w_is_mult;
  logic             w_is_signed;
  logic             w_mt_hi;
  logic             w_mt_lo;

  // ------------------------------------------------------------------
  // Operation decode
  // ------------------------------------------------------------------
  assign w_is_mult   = (md.op == c_op_mult) || (md.op == c_op_multu);
  assign w_is_signed = (md.op == c_op_mult) || (md.op == c_op_div);
  assign w_start     = md.en && !w_busy &&
                       (md.op >= c_op_mult) && (md.op <= c_op_divu);
  assign w_mt_hi     = md.en && !w_busy && (md.op == c_op_mthi);
  assign w_mt_lo     = md.en && !w_busy && (md.op == c_op_mtlo);

  // ------------------------------------------------------------------
  // Multiply: one 64-bit multiplier, operands extended per signedness
  // ------------------------------------------------------------------
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;

  assign w_ext_a = {{32{w_is_signed & md.a[31]}}, md.a};
  assign w_ext_b = {{32{w_is_signed & md.b[31]}}, md.b};
  assign w_prod  = w_ext_a * w_ext_b;

  // ------------------------------------------------------------------
  // Divide: unsigned divide on magnitudes, signs restored afterwards.
  // 0x80000000 / -1 falls out naturally as quotient 0x80000000.
  // ------------------------------------------------------------------
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_div_zero;
  logic [31:0] w_divisor;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_neg_a    = w_is_signed & md.a[31];
  assign w_neg_b    = w_is_signed & md.b[31];
  assign w_mag_a    = w_neg_a ? (~md.a + 32'd1) : md.a;
  assign w_mag_b    = w_neg_b ? (~md.b + 32'd1) : md.b;
  assign w_div_zero = (md.b == 32'd0);
  // Substitute divisor keeps the divider output defined; the result is never committed.
  assign w_divisor  = w_div_zero ? 32'd1 : w_mag_b;
  assign w_q_mag    = w_mag_a / w_divisor;
  assign w_r_mag    = w_mag_a % w_divisor;
  assign w_quot     = (w_neg_a ^ w_neg_b) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem      = w_neg_a ? (~w_r_mag + 32'd1) : w_r_mag;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (w_start) w_state_nxt = c_run;
      c_run:   if (r_cnt == '0) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy      = (r_state == c_run);
    w_stall_req = md.md_use_id && (w_busy || w_start);
  end

  // ------------------------------------------------------------------
  // Datapath: pending result, countdown, architectural HI/LO
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi_n   <= 32'd0;
      r_lo_n   <= 32'd0;
      r_commit <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else if (w_start) begin
      r_cnt    <= w_is_mult ? c_mult_load : c_div_load;
      r_hi_n   <= w_is_mult ? w_prod[63:32] : w_rem;
      r_lo_n   <= w_is_mult ? w_prod[31:0]  : w_quot;
      r_commit <= w_is_mult | ~w_div_zero;
    end else if (w_busy) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (r_commit) begin
        r_hi <= r_hi_n;
        r_lo <= r_lo_n;
      end
    end else begin
      if (w_mt_hi) r_hi <= md.a;
      if (w_mt_lo) r_lo <= md.a;
    end
  end

  assign md.busy      = w_busy;
  assign md.stall_req = w_stall_req;
  assign md.hi        = r_hi;
  assign md.lo        = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// tb_md_unit : directed + randomized bench for md_unit against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_md_unit;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: architectural registers, pending result and the edge index at which it lands.
  int          cyc      = 0;
  int          m_end    = 0;
  bit          m_valid  = 1'b0;
  bit          m_pend   = 1'b0;
  logic [31:0] m_hi     = 32'd0;
  logic [31:0] m_lo     = 32'd0;
  logic [31:0] m_pend_hi;
  logic [31:0] m_pend_lo;

  int busy_seen;
  int stall_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_compute(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] hi,
                                      output logic [31:0] lo, output bit valid);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    valid = 1'b1;
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      3'd3: begin
        if (b == 32'd0) valid = 1'b0;
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) valid = 1'b0;
        else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
      end
    endcase
  endfunction

  // One clock cycle: apply inputs, check stall_req, clock, advance model, check state.
  task automatic tick(input bit rst, input bit en, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input bit use_id);
    bit          busy_pre, start, v;
    logic [31:0] h, l;
    reset = rst; bus.en = en; bus.op = op; bus.a = a; bus.b = b; bus.md_use_id = use_id;
    #1;
    busy_pre = (cyc < m_end);
    start    = en && (op >= 3'd1) && (op <= 3'd4) && !busy_pre;
    if (m_valid) check("stall_req", 32'(bus.stall_req), 32'(use_id && (busy_pre || start)));
    if (bus.stall_req === 1'b1) stall_seen++;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_valid = 1'b1; m_pend = 1'b0; m_end = 0; m_hi = 32'd0; m_lo = 32'd0;
    end else begin
      if (m_pend && cyc == m_end) begin
        m_hi = m_pend_hi; m_lo = m_pend_lo; m_pend = 1'b0;
      end
      if (start) begin
        ref_compute(op, a, b, h, l, v);
        m_pend_hi = h; m_pend_lo = l; m_pend = v;
        m_end = cyc + ((op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES);
      end else if (en && !busy_pre && op == 3'd5) begin
        m_hi = a;
      end else if (en && !busy_pre && op == 3'd6) begin
        m_lo = a;
      end
    end
    #1;
    if (m_valid) begin
      check("busy", 32'(bus.busy), 32'(cyc < m_end));
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
    if (bus.busy === 1'b1) busy_seen++;
  endtask

  task automatic idle(input int n, input bit use_id);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, use_id);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; bus.en = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0; bus.md_use_id = 1'b0;

    // Reset
    tick(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    tick(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_stall", 32'(bus.stall_req), 32'd0);

    // mult -3 * 7
    busy_seen = 0;
    tick(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    idle(6, 1'b0);
    check("mult_busy_len", 32'(busy_seen), 32'd5);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFEB);

    // divu 100 / 7
    busy_seen = 0;
    tick(1'b0, 1'b1, 3'd4, 32'd100, 32'd7, 1'b0);
    idle(11, 1'b0);
    check("divu_busy_len", 32'(busy_seen), 32'd10);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    // div -7 / 2
    tick(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(11, 1'b0);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    // div by zero after mtlo
    tick(1'b0, 1'b1, 3'd6, 32'h0000_1234, 32'd0, 1'b0);
    check("mtlo_lo", bus.lo, 32'h0000_1234);
    busy_seen = 0;
    tick(1'b0, 1'b1, 3'd3, 32'd5, 32'd0, 1'b0);
    idle(11, 1'b0);
    check("divz_busy_len", 32'(busy_seen), 32'd10);
    check("divz_lo", bus.lo, 32'h0000_1234);
    check("divz_hi", bus.hi, 32'hFFFF_FFFF);

    // 0x80000000 / -1
    tick(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(11, 1'b0);
    check("divovf_lo", bus.lo, 32'h8000_0000);
    check("divovf_hi", bus.hi, 32'd0);

    // stall window and an ignored second mult
    stall_seen = 0;
    tick(1'b0, 1'b1, 3'd1, 32'h0001_0000, 32'h0003_0000, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 3'd1, 32'd2, 32'd3, 1'b1);
    tick(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    check("stall_len", 32'(stall_seen), 32'd6);
    check("stall_after", 32'(bus.stall_req), 32'd0);
    check("mult2_hi", bus.hi, 32'd3);
    check("mult2_lo", bus.lo, 32'd0);

    // reset in the third busy cycle of a div
    tick(1'b0, 1'b1, 3'd3, 32'd1000, 32'd3, 1'b0);
    idle(2, 1'b0);
    tick(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_hi", bus.hi, 32'd0);
    check("rst_mid_lo", bus.lo, 32'd0);
    idle(12, 1'b0);
    check("rst_nocommit_hi", bus.hi, 32'd0);
    check("rst_nocommit_lo", bus.lo, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
